// File: rtl/sram_word_controller.sv
// rtl/sram_word_controller.sv - 32-bit word load/store bridge onto a 16-bit async SRAM
// Each word is two halfword phases (low at even, high at odd halfword address).
module sram_word_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        sram_ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [16:0]       word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       read_data_q, read_data_d;
    logic [17:0]       addr_q, addr_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic              req;
    logic              phase_last;

    assign req        = MEM_R_EN | MEM_W_EN;
    assign phase_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            addr_q      <= '0;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            addr_q      <= addr_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    // Write wins when both requests are raised together.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                    op_wr_d = MEM_W_EN;
                    word_d  = 17'((address - 32'(BASE_ADDR)) >> 2);
                    wdata_d = write_data;
                end
            end
            S_LO: begin
                if (phase_last) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HI: begin
                if (phase_last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values are derived from the upcoming state so they are registered in step with it.
    always_comb begin
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        addr_d      = addr_q;
        read_data_d = read_data_q;
        if (state_d == S_LO || state_d == S_HI) begin
            ub_n_d = 1'b0;
            lb_n_d = 1'b0;
            ce_n_d = 1'b0;
            addr_d = {word_d, (state_d == S_HI)};
            if (op_wr_d) begin
                // WE_N rises one cycle before the phase ends so data and address hold past it.
                we_n_d   = (cnt_d == CNT_LAST);
                dq_oe_d  = 1'b1;
                dq_out_d = (state_d == S_HI) ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                oe_n_d = 1'b0;
            end
        end
        if (!op_wr_q && phase_last) begin
            if (state_q == S_LO) begin
                read_data_d[15:0] = SRAM_DQ;
            end else if (state_q == S_HI) begin
                read_data_d[31:16] = SRAM_DQ;
            end
        end
    end

    assign sram_ready = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
    assign read_data  = read_data_q;
    assign SRAM_ADDR  = addr_q;
    assign SRAM_UB_N  = ub_n_q;
    assign SRAM_LB_N  = lb_n_q;
    assign SRAM_CE_N  = ce_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_DQ    = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule
